// File: rtl/sb_drain_cache_port_pkg.sv
// Shared definitions for the store-buffer drain cache port: default geometry,
// FSM state encoding and address-field helpers.
package sb_drain_cache_port_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NLINES_DEF     = 4;
    localparam int LINE_WORDS_DEF = 4;
    localparam int LINE_WIDTH     = LINE_WORDS_DEF * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL
    } state_t;

    // Address layout, LSB first: byte offset | word offset | index | tag.
    function automatic int byte_off_bits(int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int line_off_bits(int data_w, int line_words);
        return $clog2(data_w / 8) + $clog2(line_words);
    endfunction

endpackage

// File: rtl/sb_drain_cache_port_if.sv
// Store-buffer drain handshake plus line-granular memory port.
// master = the cache port, slave = store buffer / memory side.
interface sb_drain_cache_port_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         sending_data_to_cache;
    logic [ADDR_W+DATA_W-1:0]     data_to_cache;
    logic                         cache_hit;
    logic                         busy;
    logic                         mem_req;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [LINE_WORDS*DATA_W-1:0] mem_wdata;
    logic [LINE_WORDS*DATA_W-1:0] mem_rdata;
    logic                         mem_ready;

    modport master (
        input  sending_data_to_cache, data_to_cache, mem_rdata, mem_ready,
        output cache_hit, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output sending_data_to_cache, data_to_cache, mem_rdata, mem_ready,
        input  cache_hit, busy, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sb_cache_array.sv
// Direct-mapped tag/valid/dirty/data storage: one index shared by a
// combinational line read, a word write (marks dirty) and a line fill.
module sb_cache_array #(
    parameter int NLINES     = 4,
    parameter int LINE_WORDS = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 26,
    localparam int IDX_W     = $clog2(NLINES),
    localparam int WOFF_W    = $clog2(LINE_WORDS),
    localparam int LINE_W    = LINE_WORDS * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              ww_en,
    input  logic [WOFF_W-1:0] ww_woff,
    input  logic [DATA_W-1:0] ww_data,
    input  logic              lw_en,
    input  logic [TAG_W-1:0]  lw_tag,
    input  logic [LINE_W-1:0] lw_line
);
    logic [NLINES-1:0]                              valid;
    logic [NLINES-1:0]                              dirty;
    logic [NLINES-1:0][TAG_W-1:0]                   tags;
    logic [NLINES-1:0][LINE_WORDS-1:0][DATA_W-1:0]  data;

    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tags[idx];
    assign rd_line  = data[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (lw_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (ww_en) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (!reset && lw_en) begin
            tags[idx] <= lw_tag;
            data[idx] <= lw_line;
        end else if (!reset && ww_en) begin
            data[idx][ww_woff] <= ww_data;
        end
    end
endmodule

// File: rtl/sb_drain_cache_port.sv
// Cache-side receiver for store-buffer drains: write-back, write-allocate,
// direct-mapped; acks each stored word with a one-cycle cache_hit.
module sb_drain_cache_port
    import sb_drain_cache_port_pkg::*;
#(
    parameter int SB_ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int SB_DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NLINES        = NLINES_DEF,
    parameter int LINE_WORDS    = LINE_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sb_drain_cache_port_if.master bus
);
    localparam int BOFF   = byte_off_bits(SB_DATA_WIDTH);
    localparam int LO     = line_off_bits(SB_DATA_WIDTH, LINE_WORDS);
    localparam int IDX_W  = $clog2(NLINES);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = SB_ADDR_WIDTH - LO - IDX_W;
    localparam int LINE_W = LINE_WORDS * SB_DATA_WIDTH;

    state_t state, state_nxt;

    logic [SB_ADDR_WIDTH-1:0] in_addr;
    logic [TAG_W-1:0]         req_tag;
    logic [IDX_W-1:0]         req_idx;
    logic [WOFF_W-1:0]        req_woff;
    logic [SB_DATA_WIDTH-1:0] req_data;

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              ww_en, lw_en;
    logic              hit, victim_dirty;
    logic              unused_byte_off;

    assign in_addr         = bus.data_to_cache[SB_ADDR_WIDTH+SB_DATA_WIDTH-1:SB_DATA_WIDTH];
    assign unused_byte_off = ^in_addr[BOFF-1:0];

    sb_cache_array #(
        .NLINES     (NLINES),
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (SB_DATA_WIDTH),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .idx      (req_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .ww_en    (ww_en),
        .ww_woff  (req_woff),
        .ww_data  (req_data),
        .lw_en    (lw_en),
        .lw_tag   (req_tag),
        .lw_line  (bus.mem_rdata)
    );

    assign hit          = rd_valid && (rd_tag == req_tag);
    assign victim_dirty = rd_valid && rd_dirty;

    // Entry is captured only in IDLE; the store buffer holds it until the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_tag  <= '0;
            req_idx  <= '0;
            req_woff <= '0;
            req_data <= '0;
        end else if (state == ST_IDLE && bus.sending_data_to_cache) begin
            req_tag  <= in_addr[SB_ADDR_WIDTH-1:LO+IDX_W];
            req_idx  <= in_addr[LO+IDX_W-1:LO];
            req_woff <= in_addr[LO-1:BOFF];
            req_data <= bus.data_to_cache[SB_DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.sending_data_to_cache) state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit)               state_nxt = ST_IDLE;
                else if (victim_dirty) state_nxt = ST_EVICT;
                else                   state_nxt = ST_FILL;
            end
            ST_EVICT:  if (bus.mem_ready) state_nxt = ST_FILL;
            ST_FILL:   if (bus.mem_ready) state_nxt = ST_LOOKUP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // After a fill the FSM returns to LOOKUP, so every store is written by the hit path.
    always_comb begin
        bus.cache_hit = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        ww_en         = 1'b0;
        lw_en         = 1'b0;
        case (state)
            ST_LOOKUP: begin
                bus.cache_hit = hit && !reset;
                ww_en         = hit && !reset;
            end
            ST_EVICT: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {rd_tag, req_idx, {LO{1'b0}}};
                bus.mem_wdata = rd_line;
            end
            ST_FILL: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = {req_tag, req_idx, {LO{1'b0}}};
                lw_en         = bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign bus.busy = (state != ST_IDLE);
endmodule

// File: tb/tb_sb_drain_cache_port.sv
// Randomised drain traffic against a line-level cache/memory model, plus
// directed scenarios with literal expectations.
module tb_sb_drain_cache_port;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sb_drain_cache_port_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) bus();

    sb_drain_cache_port #(
        .SB_ADDR_WIDTH (32),
        .SB_DATA_WIDTH (32),
        .NLINES        (4),
        .LINE_WORDS    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: what the cache holds and what memory holds, by line.
    logic         mvalid [4];
    logic         mdirty [4];
    logic [25:0]  mtag   [4];
    logic [127:0] mline  [4];
    logic [127:0] mem_model [logic [31:0]];

    logic [31:0]  obs_fill_addr, obs_wb_addr;
    logic [127:0] obs_wb_data;
    int           obs_ack_edges, obs_ack_cyc, obs_req_cycles;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = la ^ (32'h0101_0101 * (w + 1)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [127:0] mem_get(input logic [31:0] la);
        if (mem_model.exists(la)) return mem_model[la];
        return init_line(la);
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        logic [1:0] ix;
        ix = addr[5:4];
        return mvalid[ix] && (mtag[ix] == addr[31:6]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    // Outputs of an idle cache after the current cycle.
    task automatic idle_cycle(input bit spur);
        bus.mem_ready = spur;
        @(negedge clk);
        check("idle_cache_hit", bus.cache_hit, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_mem_req", bus.mem_req, 0);
        bus.mem_ready = 1'b0;
    endtask

    // Presents one entry at a negedge and follows it to its ack, checking every cycle.
    // Latencies count cycles after capture: hit acks at 1, misses after evict/fill phases.
    task automatic run_entry(input logic [31:0] addr, input logic [31:0] data,
                             input int wl, input int fl, input bit hold, input bit spur);
        logic [1:0]  ix, wo;
        logic [25:0] tg;
        logic [31:0] vaddr, faddr;
        bit          hit, ev, in_ev, in_fill;
        int          s_fill, ack;
        ix     = addr[5:4];
        wo     = addr[3:2];
        tg     = addr[31:6];
        hit    = model_hit(addr);
        ev     = !hit && mvalid[ix] && mdirty[ix];
        vaddr  = {mtag[ix], ix, 4'b0};
        faddr  = {addr[31:4], 4'b0};
        s_fill = ev ? 2 + wl : 2;
        ack    = hit ? 1 : s_fill + fl;
        obs_req_cycles = 0;
        bus.sending_data_to_cache = 1'b1;
        bus.data_to_cache         = {addr, data};
        for (int c = 1; c <= ack; c++) begin
            in_ev   = ev && c >= 2 && c <= 1 + wl;
            in_fill = !hit && c >= s_fill && c <= s_fill + fl - 1;
            @(negedge clk);
            check("cache_hit", bus.cache_hit, (c == ack));
            check("busy", bus.busy, 1);
            check("mem_req", bus.mem_req, in_ev || in_fill);
            if (bus.mem_req) obs_req_cycles++;
            if (in_ev) begin
                check("wb_we", bus.mem_we, 1);
                check("wb_addr", bus.mem_addr, vaddr);
                check("wb_data", bus.mem_wdata, mline[ix]);
                obs_wb_addr = bus.mem_addr;
                obs_wb_data = bus.mem_wdata;
            end
            if (in_fill) begin
                check("fill_we", bus.mem_we, 0);
                check("fill_addr", bus.mem_addr, faddr);
                obs_fill_addr = bus.mem_addr;
            end
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if ((in_ev && c == 1 + wl) || (in_fill && c == s_fill + fl - 1)) begin
                bus.mem_ready = 1'b1;
                if (in_fill) bus.mem_rdata = mem_get(faddr);
            end else begin
                bus.mem_ready = spur && !(in_ev || in_fill) && ($urandom_range(1) == 1);
            end
            if (c == ack) begin
                obs_ack_edges = c + 1;
                obs_ack_cyc   = cyc;
                if (!hold) bus.sending_data_to_cache = 1'b0;
            end
        end
        if (!hit) begin
            if (ev) mem_model[vaddr] = mline[ix];
            mline[ix]  = mem_get(faddr);
            mtag[ix]   = tg;
            mvalid[ix] = 1'b1;
        end
        mline[ix][wo*32 +: 32] = data;
        mdirty[ix] = 1'b1;
        idle_cycle(spur);
    endtask

    // Misses an entry, never answers memory, and resets after k cycles.
    task automatic abort_entry(input logic [31:0] addr, input logic [31:0] data, input int k);
        logic [1:0] ix;
        bit         ev;
        ix = addr[5:4];
        ev = mvalid[ix] && mdirty[ix];
        bus.sending_data_to_cache = 1'b1;
        bus.data_to_cache         = {addr, data};
        bus.mem_ready             = 1'b0;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            check("abort_busy", bus.busy, 1);
            check("abort_cache_hit", bus.cache_hit, 0);
            check("abort_mem_req", bus.mem_req, (c >= 2));
            if (c >= 2) check("abort_mem_we", bus.mem_we, ev);
        end
        reset = 1'b1;
        bus.sending_data_to_cache = 1'b0;
        bus.mem_ready = ($urandom_range(1) == 1);
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cache_hit", bus.cache_hit, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        model_reset();
    endtask

    initial begin
        int first_ack;
        bit hold;
        logic [31:0] a;
        reset = 1'b1;
        bus.sending_data_to_cache = 1'b0;
        bus.data_to_cache = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_cache_hit", bus.cache_hit, 0);
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_mem_we", bus.mem_we, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;

        // Clean miss into index 2, fill answered on the third fill cycle.
        run_entry(32'h0000_00AA, 32'h0000_DDDD, 1, 3, 0, 0);
        check("t1_fill_addr", obs_fill_addr, 32'hA0);
        check("t1_ack_edges", obs_ack_edges, 6);
        // Miss into index 3 must leave index 2 alone (verified by the later eviction).
        run_entry(32'h0000_00BB, 32'h0000_FFFF, 1, 2, 0, 0);
        check("t2_fill_addr", obs_fill_addr, 32'hB0);
        // Hit: two edges to ack, no memory traffic.
        run_entry(32'h0000_00A4, 32'h0000_1234, 1, 1, 0, 0);
        check("t3_ack_edges", obs_ack_edges, 2);
        check("t3_req_cycles", obs_req_cycles, 0);
        // Conflict on index 2 with dirty victim.
        run_entry(32'h0000_01A0, 32'hCAFE_0000, 2, 2, 0, 0);
        check("t4_wb_addr", obs_wb_addr, 32'hA0);
        check("t4_wb_word1", obs_wb_data[63:32], 32'h0000_1234);
        check("t4_wb_word2", obs_wb_data[95:64], 32'h0000_DDDD);
        check("t4_fill_addr", obs_fill_addr, 32'h1A0);
        check("t4_ack_edges", obs_ack_edges, 7);
        run_entry(32'h0000_00A0, 32'h0000_0001, 1, 1, 0, 0);
        check("t4_dirty_wb_addr", obs_wb_addr, 32'h1A0);
        check("t4_dirty_wb_word0", obs_wb_data[31:0], 32'hCAFE_0000);
        // Reset two cycles into a clean fill; index 2 is then empty again.
        abort_entry(32'h0000_00C0, 32'h0BAD_0BAD, 4);
        run_entry(32'h0000_00AA, 32'h0000_DDDD, 1, 1, 0, 0);
        check("t5_refill_addr", obs_fill_addr, 32'hA0);
        check("t5_ack_edges", obs_ack_edges, 4);
        // Two held hits back to back, spurious mem_ready in between.
        run_entry(32'h0000_00A4, 32'h0000_1111, 1, 1, 1, 1);
        first_ack = obs_ack_cyc;
        run_entry(32'h0000_00A8, 32'h0000_2222, 1, 1, 0, 1);
        check("t6_ack_spacing", obs_ack_cyc - first_ack, 2);
        check("t6_ack_edges", obs_ack_edges, 2);

        hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a = {24'h0, 6'h0, 2'h0};
            a[31:6] = 26'($urandom_range(3));
            a[5:0]  = 6'($urandom);
            if (!model_hit(a) && $urandom_range(24) == 0) begin
                abort_entry(a, $urandom, $urandom_range(6, 2));
                hold = 1'b0;
            end else begin
                hold = ($urandom_range(1) == 1);
                run_entry(a, $urandom, $urandom_range(4, 1), $urandom_range(4, 1),
                          hold, ($urandom_range(1) == 1));
                if (!hold) repeat ($urandom_range(2)) idle_cycle($urandom_range(1) == 1);
            end
        end
        bus.sending_data_to_cache = 1'b0;
        idle_cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
